// File: rtl/dw_fifo_sync.sv
// Synchronous FIFO on a flip-flop array with fall-through head read and
// count-derived status flags. Depth need not be a power of two.
module dw_fifo_sync #(
  parameter int width    = 8,
  parameter int depth    = 16,
  parameter int ae_level = 1,
  parameter int af_level = 1,
  parameter int err_mode = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_req_n,
  input  logic             pop_req_n,
  input  logic [width-1:0] data_in,
  output logic             empty,
  output logic             almost_empty,
  output logic             half_full,
  output logic             almost_full,
  output logic             full,
  output logic             error,
  output logic [width-1:0] data_out
);

  localparam int CW = $clog2(depth + 1);
  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);
  localparam logic [CW-1:0] AE_C    = CW'(ae_level);
  localparam logic [CW-1:0] HF_C    = CW'((depth + 1) / 2);
  localparam logic [CW-1:0] AF_C    = CW'(depth - af_level);
  localparam logic [PW-1:0] LAST_P  = PW'(depth - 1);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop, do_push, do_pop, overflow, underflow;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  assign push      = ~push_req_n;
  assign pop       = ~pop_req_n;
  assign do_pop    = pop & ~empty;
  // When full, a concurrent pop frees the head slot, which is where wr_ptr points.
  assign do_push   = push & (~full | do_pop);
  assign overflow  = push & full & ~pop;
  assign underflow = pop & empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      error  <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (err_mode == 0) error <= error | overflow | underflow;
      else               error <= overflow | underflow;
    end
  end

  // Flags depend only on the count register, never on the request inputs.
  assign empty        = (count == '0);
  assign almost_empty = (count <= AE_C);
  assign half_full    = (count >= HF_C);
  assign almost_full  = (count >= AF_C);
  assign full         = (count == DEPTH_C);
  assign data_out     = mem[rd_ptr];

endmodule

// File: tb/tb_dw_fifo_sync.sv
// Scoreboard bench for dw_fifo_sync: a queue-based reference model predicts
// popped words and status flags for a depth-16 sticky and a depth-5 pulse instance.
module tb_dw_fifo_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push_req_n = 1'b1, pop_req_n = 1'b1;
  logic [7:0] data_in = '0;

  logic       e0, ae0, hf0, af0, f0, err0;
  logic       e1, ae1, hf1, af1, f1, err1;
  logic [7:0] do0, do1;

  always #5 clk = ~clk;

  dw_fifo_sync #(.width(8), .depth(16), .ae_level(1), .af_level(1), .err_mode(0)) u0 (
    .clk(clk), .rst(rst), .push_req_n(push_req_n), .pop_req_n(pop_req_n), .data_in(data_in),
    .empty(e0), .almost_empty(ae0), .half_full(hf0), .almost_full(af0), .full(f0),
    .error(err0), .data_out(do0));

  dw_fifo_sync #(.width(8), .depth(5), .ae_level(2), .af_level(2), .err_mode(1)) u1 (
    .clk(clk), .rst(rst), .push_req_n(push_req_n), .pop_req_n(pop_req_n), .data_in(data_in),
    .empty(e1), .almost_empty(ae1), .half_full(hf1), .almost_full(af1), .full(f1),
    .error(err1), .data_out(do1));

  // Which instance is under observation
  bit sel = 1'b0;
  wire       d_empty = sel ? e1   : e0;
  wire       d_ae    = sel ? ae1  : ae0;
  wire       d_hf    = sel ? hf1  : hf0;
  wire       d_af    = sel ? af1  : af0;
  wire       d_full  = sel ? f1   : f0;
  wire       d_err   = sel ? err1 : err0;
  wire [7:0] d_dout  = sel ? do1  : do0;

  // Reference model
  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  bit  merr = 1'b0;
  int  mdepth = 16, merrmode = 0, mae = 1, maf = 1;
  bit  chk_en = 1'b0;

  int asserts = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock cycle of stimulus; expectations for any pop are issued before the edge.
  task automatic cyc(input bit ps, input bit pp, input logic [7:0] d, input bit r = 1'b0);
    bit ovf, unf, popd, pushd;
    push_req_n = ~ps;
    pop_req_n  = ~pp;
    data_in    = d;
    rst        = r;
    if (!r && pp && q.size() > 0) exp_q.push_back(q[0]);
    @(posedge clk);
    if (r) begin
      q.delete();
      merr = 1'b0;
    end else begin
      ovf   = ps && q.size() == mdepth && !pp;
      unf   = pp && q.size() == 0;
      popd  = pp && q.size() > 0;
      pushd = ps && (q.size() < mdepth || popd);
      if (popd)  void'(q.pop_front());
      if (pushd) q.push_back(d);
      merr = (merrmode != 0) ? (ovf | unf) : (merr | ovf | unf);
    end
    #1;
  endtask

  task automatic do_reset();
    cyc(0, 0, 8'h00, 1'b1);
    cyc(0, 0, 8'h00, 1'b1);
    cyc(0, 0, 8'h00, 1'b0);
  endtask

  // Monitor: compares popped heads and all flags every cycle.
  initial begin
    int n;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        n = q.size();
        if (!rst && !pop_req_n && !d_empty) begin
          if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
          else chk("pop_data", {24'd0, d_dout}, {24'd0, exp_q.pop_front()});
        end
        chk("empty",        {31'd0, d_empty}, {31'd0, n == 0});
        chk("almost_empty", {31'd0, d_ae},    {31'd0, n <= mae});
        chk("half_full",    {31'd0, d_hf},    {31'd0, n >= (mdepth + 1) / 2});
        chk("almost_full",  {31'd0, d_af},    {31'd0, n >= mdepth - maf});
        chk("full",         {31'd0, d_full},  {31'd0, n == mdepth});
        chk("error",        {31'd0, d_err},   {31'd0, merr});
        if (n > 0) chk("head", {24'd0, d_dout}, {24'd0, q[0]});
      end
    end
  end

  initial begin
    logic [7:0] v;
    // ---------------- depth 16, sticky error ----------------
    do_reset();
    chk_en = 1'b1;
    #2 chk("reset_dout", {24'd0, d_dout}, 32'd0);

    // In-order basic traffic
    cyc(1, 0, 8'h11); cyc(1, 0, 8'h22); cyc(1, 0, 8'h33);
    cyc(0, 1, 8'h00); cyc(0, 1, 8'h00); cyc(0, 1, 8'h00);
    cyc(0, 0, 8'h00);

    // Fill to full, then overflow once: contents must survive
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'h40 + 8'(i));
    cyc(1, 0, 8'hEE);
    cyc(0, 0, 8'h00);
    // Sustained push+pop while full across pointer wrap
    for (int i = 0; i < 40; i++) cyc(1, 1, 8'h80 + 8'(i));
    for (int i = 0; i < 16; i++) cyc(0, 1, 8'h00);
    cyc(0, 0, 8'h00);

    // Push+pop while empty: push lands, underflow flagged
    do_reset();
    cyc(1, 1, 8'hA5);
    cyc(0, 0, 8'h00);
    cyc(0, 1, 8'h00);

    // Reset during a push with seven words queued
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1, 0, 8'h60 + 8'(i));
    cyc(1, 0, 8'hDD, 1'b1);
    cyc(1, 0, 8'h5A);
    cyc(0, 1, 8'h00);
    cyc(0, 0, 8'h00);

    // Random traffic with shifting push/pop bias
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int bias = (i / 100) % 2 ? 30 : 70;
      v = 8'($urandom);
      cyc($urandom_range(99) < bias, $urandom_range(99) >= bias - 20, v);
    end

    // ---------------- depth 5, pulsed error ----------------
    chk_en = 1'b0;
    sel = 1'b1; mdepth = 5; merrmode = 1; mae = 2; maf = 2;
    do_reset();
    chk_en = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'hC0 + 8'(i));
    cyc(1, 0, 8'hFF);
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h00);
    cyc(0, 0, 8'h00);
    for (int i = 0; i < 300; i++) begin
      v = 8'($urandom);
      cyc($urandom_range(1), $urandom_range(1), v);
    end
    for (int i = 0; i < 6; i++) cyc(0, 1, 8'h00);
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);

    chk("expect_q_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/dw_fifo_sync.md
DW_FIFO_SYNC -- requirements
Module: dw_fifo_sync

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter width, default 8, SHALL set the data word width in bits (1..256).
REQ-003 Parameter depth, default 16, SHALL set the number of storage words (2..256; need not be a power of two).
REQ-004 Parameter ae_level, default 1, SHALL set the almost_empty threshold (1..depth-1).
REQ-005 Parameter af_level, default 1, SHALL set the almost_full threshold (1..depth-1).
REQ-006 Parameter err_mode, default 0, SHALL select the error behaviour: 0 = sticky, 1 = one-cycle pulse.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 rst  input  1  synchronous reset, active-high.
REQ-009 push_req_n  input  1  push request, active-low.
REQ-010 pop_req_n  input  1  pop request, active-low.
REQ-011 data_in  input  width  push data.
REQ-012 empty  output  1  high when count==0.
REQ-013 almost_empty  output  1  high when count<=ae_level.
REQ-014 half_full  output  1  high when count>=(depth+1)/2, using integer division.
REQ-015 almost_full  output  1  high when count>=depth-af_level.
REQ-016 full  output  1  high when count==depth.
REQ-017 error  output  1  overflow/underflow indicator.
REQ-018 data_out  output  width  oldest stored word (head of queue).

Function
REQ-019 The block SHALL be a first-in-first-out queue: words SHALL leave in push order (the FIFO counterpart of the team's LIFO stack).
REQ-020 Storage SHALL be a flip-flop array of depth x width, with a write pointer wr_ptr, a read pointer rd_ptr, and a count register of ceil(log2(depth+1)) bits.
REQ-021 A push with the FIFO not full SHALL write data_in to mem[wr_ptr] at the clock edge and advance wr_ptr.
REQ-022 A pop with the FIFO not empty SHALL advance rd_ptr at the clock edge.
REQ-023 data_out SHALL be a combinational read of mem[rd_ptr] with zero-cycle fall-through, so the head word is visible while empty==0.
REQ-024 data_out SHALL be don't-care while empty==1 and SHALL NOT be X after reset; the array is reset to 0.
REQ-025 Each pointer SHALL wrap from depth-1 to 0; increments SHALL be explicit compare-and-clear, not modulo 2^n.
REQ-026 count SHALL increment on a push-only, decrement on a pop-only, and remain unchanged on a simultaneous push+pop that both take effect.
REQ-027 Push while full with no pop SHALL be ignored (no write, no pointer or count change) and SHALL be an overflow error.
REQ-028 Pop while empty SHALL be ignored and SHALL be an underflow error; a simultaneous push SHALL still be performed (count 0->1).
REQ-029 Simultaneous push+pop while full SHALL perform both operations (pop the head, write at the freed slot), with count remaining depth and no error.
REQ-030 All flags SHALL be registered-equivalent, derived from the count register only, and valid the cycle after each edge; there SHALL be no combinational path from the request inputs.
REQ-031 With err_mode=0, error SHALL set on the first overflow or underflow and hold until reset.
REQ-032 With err_mode=1, error SHALL be high for exactly the cycle following each offending edge.

Reset
REQ-033 On a clock edge with rst=1, the block SHALL set wr_ptr=0, rd_ptr=0, count=0, and error=0, and clear the array to 0; requests on that edge SHALL be ignored.
REQ-034 After reset the outputs SHALL be empty=1, almost_empty=1, half_full=0, almost_full=0, full=0, error=0, and data_out=0.
REQ-035 Reset asserted mid-operation SHALL discard all contents at that edge, with no partial write.

Verification
REQ-036 Reset, then push 0x11,0x22,0x33, then pop three times -> data_out shows 0x11, 0x22, 0x33 in order, then empty=1, error=0.
REQ-037 Defaults: push 16 words -> full=1 after the 16th push, almost_full=1 from count 15, half_full=1 from count 8; a 17th push -> error=1 (sticky) and contents unchanged.
REQ-038 When empty, assert push and pop together with data_in=0xA5 -> count=1, data_out=0xA5, error=1 (underflow).
REQ-039 When full, assert push and pop together for 40 cycles with an incrementing pattern -> count stays 16, order is preserved across pointer wrap, error=0.
REQ-040 depth=5 with err_mode=1: fill, then overflow once -> error high for exactly 1 cycle; drain fully -> values match, and the pointers wrap 4->0.
REQ-041 Assert rst with count=7 during a push -> next cycle empty=1 and count=0, and a subsequent push/pop returns only the new data.
